// File: rtl/phase_selector.sv
// Picks the best of eight oversampling phases from per-window transition histograms
// and tracks it with a SEARCH/CONFIRM/LOCKED state machine.
module phase_selector #(
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned MIN_TRANS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] samples,
    input  logic [7:0] trans,
    output logic       dout,
    output logic       dout_valid,
    output logic [2:0] phase,
    output logic       locked,
    output logic [1:0] slip
);

    localparam int unsigned WW = $clog2(WINDOW);
    localparam int unsigned CW = WW + 1;
    localparam int unsigned SW = CW + 3;

    typedef enum logic [1:0] {
        StSearch,
        StConfirm,
        StLocked
    } state_e;

    state_e          r_state;
    logic [WW-1:0]   r_win_cnt;
    logic [CW-1:0]   r_cnt [8];
    logic [2:0]      r_phase;
    logic [2:0]      r_pending;
    logic            r_locked;
    logic [1:0]      r_slip;
    logic            r_dout;
    logic            r_dout_valid;

    logic            w_eow;
    logic [CW-1:0]   w_eval [8];
    logic [CW-1:0]   w_best_val;
    logic [2:0]      w_best_idx;
    logic [SW-1:0]   w_sum;
    logic [2:0]      w_cand;
    logic [2:0]      w_diff;
    logic            w_win_ok;

    assign w_eow = (r_win_cnt == WW'(WINDOW - 1));

    // Evaluation includes this clock's flags; strict compare keeps the lowest index on ties.
    always_comb begin
        w_sum      = '0;
        w_best_val = '0;
        w_best_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_eval[i] = r_cnt[i] + CW'(trans[i]);
            w_sum     = w_sum + SW'(w_eval[i]);
        end
        w_best_val = w_eval[0];
        for (int i = 1; i < 8; i++) begin
            if (w_eval[i] > w_best_val) begin
                w_best_val = w_eval[i];
                w_best_idx = 3'(i);
            end
        end
    end

    assign w_cand   = w_best_idx + 3'd4;
    assign w_diff   = w_cand - r_phase;
    assign w_win_ok = w_eow && (w_sum >= SW'(MIN_TRANS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + WW'(1);
            for (int i = 0; i < 8; i++) r_cnt[i] <= w_eow ? '0 : w_eval[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StSearch;
            r_phase   <= 3'd0;
            r_pending <= 3'd0;
            r_locked  <= 1'b0;
            r_slip    <= 2'b00;
        end else begin
            r_slip <= 2'b00;
            if (w_win_ok) begin
                unique case (r_state)
                    StSearch: begin
                        r_pending <= w_cand;
                        r_state   <= StConfirm;
                    end
                    StConfirm: begin
                        if (w_cand == r_pending) begin
                            r_phase  <= w_cand;
                            r_state  <= StLocked;
                            r_locked <= 1'b1;
                        end else begin
                            r_pending <= w_cand;
                        end
                    end
                    StLocked: begin
                        if (w_diff == 3'd1 || w_diff == 3'd7) begin
                            r_phase <= w_cand;
                            if (r_phase == 3'd7 && w_cand == 3'd0) begin
                                r_slip <= 2'b01;
                            end else if (r_phase == 3'd0 && w_cand == 3'd7) begin
                                r_slip <= 2'b10;
                            end
                        end else if (w_diff != 3'd0) begin
                            r_state  <= StSearch;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= StSearch;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout       <= samples[r_phase];
            r_dout_valid <= r_locked;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign phase      = r_phase;
    assign locked     = r_locked;
    assign slip       = r_slip;

endmodule

// File: tb/tb_phase_selector.sv
// Directed bench for phase_selector: lock, ties, tracking with slips, unlock,
// the MIN_TRANS threshold and asynchronous reset, all with hand-derived expectations.
module tb_phase_selector;

    logic       clk;
    logic       reset_n;
    logic [7:0] samples;
    logic [7:0] trans;
    logic       dout;
    logic       dout_valid;
    logic [2:0] phase;
    logic       locked;
    logic [1:0] slip;

    int n_cmp;
    int n_err;

    phase_selector #(
        .WINDOW    (64),
        .MIN_TRANS (8)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .samples    (samples),
        .trans      (trans),
        .dout       (dout),
        .dout_valid (dout_valid),
        .phase      (phase),
        .locked     (locked),
        .slip       (slip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic [7:0] s, input logic [7:0] t);
        @(negedge clk);
        samples = s;
        trans   = t;
        @(posedge clk);
        #1;
    endtask

    // trans = t on the first ntrans clocks, 0 afterwards; chk_phase >= 0 checks dout
    // against that sampling phase and slip idle on all but the final clock.
    task automatic run_steps(input logic [7:0] t, input int ntrans, input int nsteps,
                             input int chk_phase, input bit alt);
        logic [7:0] s;
        for (int k = 0; k < nsteps; k++) begin
            s = alt ? ((k % 2 == 1) ? 8'hFF : 8'h00) : 8'($urandom);
            step(s, (k < ntrans) ? t : 8'h00);
            if (chk_phase >= 0) begin
                check_eq("dout", 32'(dout), 32'(s[chk_phase]));
                if (k < nsteps - 1) check_eq("slip_idle", 32'(slip), 32'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, 32'(phase), 32'd0);
        check_eq({tag, "_locked"}, 32'(locked), 32'd0);
        check_eq({tag, "_dout"}, 32'(dout), 32'd0);
        check_eq({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check_eq({tag, "_slip"}, 32'(slip), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        samples = 8'hFF;
        trans   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        trans = 8'h00;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Clean edge on trans[2]: CONFIRM after one window, LOCKED at phase 6 after two.
        run_steps(8'h04, 64, 64, -1, 1'b1);
        check_eq("w1_locked", 32'(locked), 32'd0);
        check_eq("w1_phase", 32'(phase), 32'd0);
        run_steps(8'h04, 64, 64, -1, 1'b1);
        check_eq("w2_locked", 32'(locked), 32'd1);
        check_eq("w2_phase", 32'(phase), 32'd6);
        check_eq("w2_dout_valid", 32'(dout_valid), 32'd0);
        run_steps(8'h04, 64, 64, 6, 1'b1);
        check_eq("w3_dout_valid", 32'(dout_valid), 32'd1);
        check_eq("w3_locked", 32'(locked), 32'd1);

        // Idle data for three windows changes nothing.
        run_steps(8'h00, 0, 192, 6, 1'b0);
        check_eq("idle_locked", 32'(locked), 32'd1);
        check_eq("idle_phase", 32'(phase), 32'd6);

        // 7 transitions (below threshold) ignored; 8 accepted -> C=4, distance 2 -> SEARCH.
        run_steps(8'h01, 7, 64, 6, 1'b0);
        check_eq("min7_locked", 32'(locked), 32'd1);
        check_eq("min7_phase", 32'(phase), 32'd6);
        run_steps(8'h01, 8, 64, 6, 1'b0);
        check_eq("min8_locked", 32'(locked), 32'd0);
        check_eq("min8_phase", 32'(phase), 32'd6);
        check_eq("min8_dout_valid", 32'(dout_valid), 32'd1);

        // Tie between trans[2] and trans[5] resolves to E=2 -> phase 6.
        run_steps(8'h24, 1, 1, -1, 1'b0);
        check_eq("tie_dout_valid_drop", 32'(dout_valid), 32'd0);
        run_steps(8'h24, 63, 63, -1, 1'b0);
        check_eq("tie1_locked", 32'(locked), 32'd0);
        run_steps(8'h24, 64, 64, -1, 1'b0);
        check_eq("tie2_locked", 32'(locked), 32'd1);
        check_eq("tie2_phase", 32'(phase), 32'd6);

        // Edge jumps to trans[6]: unlock, then relock at phase 2 after two windows.
        run_steps(8'h40, 64, 64, 6, 1'b0);
        check_eq("jump_locked", 32'(locked), 32'd0);
        check_eq("jump_dout_valid", 32'(dout_valid), 32'd1);
        run_steps(8'h40, 1, 1, -1, 1'b0);
        check_eq("jump_dout_valid_drop", 32'(dout_valid), 32'd0);
        run_steps(8'h40, 63, 63, -1, 1'b0);
        check_eq("jump1_locked", 32'(locked), 32'd0);
        check_eq("jump1_phase_hold", 32'(phase), 32'd6);
        run_steps(8'h40, 64, 64, -1, 1'b0);
        check_eq("jump2_locked", 32'(locked), 32'd1);
        check_eq("jump2_phase", 32'(phase), 32'd2);

        // Tracking 2 -> 3 without slip.
        run_steps(8'h80, 64, 64, 2, 1'b0);
        check_eq("trk23_phase", 32'(phase), 32'd3);
        check_eq("trk23_slip", 32'(slip), 32'd0);
        check_eq("trk23_locked", 32'(locked), 32'd1);

        // Edge at trans[3]: C=7 is 4 away -> SEARCH, then lock at 7 without slip.
        run_steps(8'h08, 64, 64, 3, 1'b0);
        check_eq("to7_locked", 32'(locked), 32'd0);
        run_steps(8'h08, 128, 128, -1, 1'b0);
        check_eq("lock7_locked", 32'(locked), 32'd1);
        check_eq("lock7_phase", 32'(phase), 32'd7);
        check_eq("lock7_slip", 32'(slip), 32'd0);

        // 7 -> 0 tracking slips 01; new phase used for the very next sample.
        run_steps(8'h10, 64, 64, 7, 1'b0);
        check_eq("slip01", 32'(slip), 32'd1);
        check_eq("slip01_phase", 32'(phase), 32'd0);
        check_eq("slip01_locked", 32'(locked), 32'd1);
        run_steps(8'h10, 1, 1, 0, 1'b0);
        check_eq("slip01_pulse_end", 32'(slip), 32'd0);
        run_steps(8'h10, 63, 63, 0, 1'b0);
        check_eq("hold0_phase", 32'(phase), 32'd0);

        // 0 -> 7 tracking slips 10.
        run_steps(8'h08, 64, 64, 0, 1'b0);
        check_eq("slip10", 32'(slip), 32'd2);
        check_eq("slip10_phase", 32'(phase), 32'd7);
        run_steps(8'h08, 1, 1, 7, 1'b0);
        check_eq("slip10_pulse_end", 32'(slip), 32'd0);
        run_steps(8'h08, 63, 63, 7, 1'b0);
        check_eq("hold7_locked", 32'(locked), 32'd1);

        // Asynchronous reset mid-window while locked; window count restarts from 0.
        run_steps(8'h08, 30, 30, 7, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        trans = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_steps(8'h04, 127, 127, -1, 1'b0);
        check_eq("relock_early", 32'(locked), 32'd0);
        run_steps(8'h04, 1, 1, -1, 1'b0);
        check_eq("relock_locked", 32'(locked), 32'd1);
        check_eq("relock_phase", 32'(phase), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phase_selector.md
PHASE_SELECTOR -- requirements
Module: phase_selector

Interface
REQ-001 Parameter WINDOW, default 64: clocks per transition-histogram window (power of two, 16..1024).
REQ-002 Parameter MIN_TRANS, default 8: minimum total transitions in a window for the window's result to be used.
REQ-003 clk  input  1  sampling clock, same as oversampler phase 0; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 samples  input  8  oversampled data of one bit period; bit 0 earliest.
REQ-006 trans  input  8  per-phase transition flags; trans[i] = 1 means an edge between sample i and i+1.
REQ-007 dout  output  1  recovered data bit.
REQ-008 dout_valid  output  1  dout carries a valid bit (high only while locked).
REQ-009 phase  output  3  currently selected sampling phase.
REQ-010 locked  output  1  phase lock status.
REQ-011 slip  output  2  one-clock pulse: 01 = phase wrapped 7->0, 10 = phase wrapped 0->7, 00 otherwise.

Function
REQ-012 Eight per-phase counters SHALL each add trans[i] every clock; width clog2(WINDOW)+1, no overflow possible.
REQ-013 A window counter SHALL count 0..WINDOW-1 and wrap; the clock where it equals WINDOW-1 is end-of-window (EOW).
REQ-014 At EOW the counters SHALL be evaluated including that clock's trans, then cleared to 0 on the next edge (that clock's trans is not carried over).
REQ-015 Best edge phase E = index of the largest counter; ties resolve to the lowest index.
REQ-016 Candidate sampling phase C = (E + 4) mod 8.
REQ-017 If the sum of all counters < MIN_TRANS at EOW, the window SHALL be ignored: no state, phase, or lock change.
REQ-018 FSM states: SEARCH (reset state), CONFIRM, LOCKED.
REQ-019 SEARCH: on valid EOW, store C as pending phase, go to CONFIRM.
REQ-020 CONFIRM: on valid EOW, if C equals pending phase, set phase = C, go to LOCKED; otherwise store new C as pending and remain in CONFIRM.
REQ-021 LOCKED: on valid EOW, circular distance d between C and phase; d = 0 no change; d = 1 phase <= C (tracking); d >= 2 go to SEARCH.
REQ-022 locked SHALL be 1 exactly while the FSM is in LOCKED, updated on the same edge as the state change.
REQ-023 dout SHALL be samples[phase] registered; latency one clock from samples to dout.
REQ-024 dout_valid SHALL be the registered value of locked, aligned with dout.
REQ-025 On a tracking step 7->0, slip SHALL be 01 for one clock concurrent with the phase update; on 0->7, slip SHALL be 10; no other transition asserts slip.
REQ-026 Entering LOCKED from CONFIRM SHALL NOT assert slip regardless of phase values.
REQ-027 phase SHALL hold its last value in SEARCH and CONFIRM.
REQ-028 Simultaneous EOW and tracking: the new phase takes effect for the sample captured on the following clock.

Reset
REQ-029 While reset_n = 0: state SEARCH, all counters 0, phase 0, pending 0, dout 0, dout_valid 0, locked 0, slip 00.
REQ-030 Reset asserted mid-window or while LOCKED SHALL abort immediately; after release the first window starts at count 0.

Verification
REQ-031 Clean 0101 pattern with edges on trans[2] every clock, WINDOW=64 -> locked = 1 at end of 2nd window, phase = 6, dout alternating with 1-clock latency.
REQ-032 Edges on trans[2] and trans[5] equal counts -> E = 2, phase = 6.
REQ-033 Locked at phase 7, edge position moves to trans[4] -> phase becomes 0, single slip = 01 pulse, locked stays 1.
REQ-034 Locked at phase 6, edge position jumps to trans[6] -> SEARCH, locked and dout_valid drop; relock at phase 2 after two further windows.
REQ-035 Constant data (trans = 0) for 3 windows while locked -> state, phase, locked unchanged.
REQ-036 reset_n pulsed low mid-window while locked -> all outputs 0 asynchronously; relock takes two full windows after release.
